// File: rtl/hazard_pkg.sv
// Shared scoreboard entry type, forward-select encoding and default parameters for the hazard unit.
package hazard_pkg;

    localparam int REG_AW_DEF     = 5;
    localparam int NSTAGE_DEF     = 3;
    localparam int LOAD_STAGE_DEF = 2;
    localparam int BR_STAGE_DEF   = 2;

    // Scoreboard rd field is sized for register addresses up to 8 bits; narrower ones are zero-extended.
    localparam int SB_RD_W = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               regwrite;
        logic               memread;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Purpose: compare one ID source address against one scoreboard entry.
// Latency: purely combinational.
// Backpressure: none; consumed by the hazard unit's stall/forward logic.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  sb_entry_t         entry,
    output logic              hit,
    output logic              load_hit
);

    logic [SB_RD_W-1:0] src_ext;

    always_comb begin
        src_ext             = '0;
        src_ext[REG_AW-1:0] = src;
    end

    // x0 is hardwired, so it never creates a dependency.
    assign hit      = src_used && (src != '0) && entry.valid && entry.regwrite && (entry.rd == src_ext);
    assign load_hit = hit && entry.memread;

endmodule

// File: rtl/hazard_unit_p.sv
// Purpose: pipeline hazard detection (load-use stall, redirect flush) and registered EX forward selects.
// Latency: stall/flush combinational from ID inputs; forward selects valid the cycle after ID acceptance.
// Backpressure: stall holds PC and IF/ID and bubbles EX; flush overrides stall.
module hazard_unit_p
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NSTAGE     = NSTAGE_DEF,
    parameter int LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int BR_STAGE   = BR_STAGE_DEF,
    parameter int SELW       = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic [SELW-1:0]   fwd1_sel,
    output logic [SELW-1:0]   fwd2_sel,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    function automatic logic [NSTAGE:1] load_mask();
        logic [NSTAGE:1] m;
        for (int k = 1; k <= NSTAGE; k++) m[k] = (k < LOAD_STAGE);
        return m;
    endfunction

    localparam logic [NSTAGE:1] LOAD_MASK = load_mask();

    // Smallest matching slot wins; the select names the producer's slot as seen while the consumer was in ID.
    // A producer only in the last slot is already written through the register file.
    function automatic logic [SELW-1:0] youngest(input logic [NSTAGE:1] h);
        logic [SELW-1:0] sel;
        sel = SELW'(FWD_RF);
        for (int k = NSTAGE; k >= 1; k--) begin
            if (h[k]) sel = (k == NSTAGE) ? SELW'(FWD_RF) : SELW'(k);
        end
        return sel;
    endfunction

    sb_entry_t       sb_q [1:NSTAGE];
    sb_entry_t       sb_d [1:NSTAGE];
    sb_entry_t       id_entry;
    logic [NSTAGE:1] hit1;
    logic [NSTAGE:1] hit2;
    logic [NSTAGE:1] lhit1;
    logic [NSTAGE:1] lhit2;
    logic            accept;

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_match
        hazard_match #(.REG_AW(REG_AW)) u_match1 (
            .src      (id_rs1),
            .src_used (id_rs1_used),
            .entry    (sb_q[k]),
            .hit      (hit1[k]),
            .load_hit (lhit1[k])
        );
        hazard_match #(.REG_AW(REG_AW)) u_match2 (
            .src      (id_rs2),
            .src_used (id_rs2_used),
            .entry    (sb_q[k]),
            .hit      (hit2[k]),
            .load_hit (lhit2[k])
        );
    end

    assign flush  = br_taken && rstn;
    assign stall  = id_valid && !flush && (|((lhit1 | lhit2) & LOAD_MASK));
    assign accept = id_valid && !stall && !flush;

    always_comb begin
        id_entry                = SB_BUBBLE;
        id_entry.valid          = 1'b1;
        id_entry.rd[REG_AW-1:0] = id_rd;
        id_entry.regwrite       = id_regwrite;
        id_entry.memread        = id_memread;
    end

    // Flush kills everything younger than the branch in BR_STAGE; the branch itself moves on.
    always_comb begin
        sb_d[1] = accept ? id_entry : SB_BUBBLE;
        for (int k = 2; k <= NSTAGE; k++) begin
            sb_d[k] = (flush && (k <= BR_STAGE)) ? SB_BUBBLE : sb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 1; k <= NSTAGE; k++) sb_q[k] <= SB_BUBBLE;
            fwd1_sel  <= SELW'(FWD_RF);
            fwd2_sel  <= SELW'(FWD_RF);
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb_q      <= sb_d;
            fwd1_sel  <= accept ? youngest(hit1) : SELW'(FWD_RF);
            fwd2_sel  <= accept ? youngest(hit2) : SELW'(FWD_RF);
            stall_cnt <= stall_cnt + 32'(stall);
            flush_cnt <= flush_cnt + 32'(flush);
        end
    end

endmodule
